conv_encoder_tb: RTL and testbench
==================================

// Module: conv_encoder_tb
// PURPOSE
//   Rate-1/2 tail-biting convolutional encoder (K=7, G1=171o, G2=133o, 802.16 style).
//   Sits directly downstream of the Randomizer and takes its serial data_out stream.
//   Buffers one N-bit block, preloads the encoder state with the block's last 6 bits,
//   then emits one X/Y coded pair per clock toward the interleaver.
// PARAMETERS
//   N   96   block length in bits; legal range N >= 7
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   reset      in   1  synchronous, active-high reset
//   in_valid   in   1  data_in carries a valid bit this cycle
//   data_in    in   1  serial randomized bit; first bit received is u[0]
//   in_ready   out  1  encoder accepts a bit; drives Randomizer enable upstream
//   out_valid  out  1  x_out/y_out valid this cycle
//   x_out      out  1  G1 output bit for u[n]
//   y_out      out  1  G2 output bit for u[n]
//   out_last   out  1  high with the pair for u[N-1]
// BEHAVIOUR
//   Reset (sync): state=LOAD, bit counter=0, in_ready=1, out_valid=0, x_out=0,
//     y_out=0, out_last=0. Buffer contents are don't-care.
//   Reset mid-block, in either state: the partial block is discarded with no output.
//     Next cycle, the block restarts at u[0].
//   FSM LOAD: in_ready=1.
//     - Each cycle with in_valid=1: buf[cnt]<=data_in and cnt++.
//     - Cycles with in_valid=0: no change.
//     - When bit N-1 is accepted: go to ENCODE, cnt<=0,
//       state reg s[k]<=u[N-k] for k=1..6, with s[1]=u[N-1] (tail-biting preload).
//   FSM ENCODE: in_ready=0; in_valid is ignored and the bit is not stored.
//     - One pair per cycle for n=0..N-1:
//       X=u[n]^s1^s2^s3^s6,  Y=u[n]^s2^s3^s5^s6.
//     - Then shift s<= {u[n],s1..s5}.
//     - Outputs are registered, so out_valid rises the cycle after the last input bit is accepted.
//     - out_valid stays high for exactly N consecutive cycles; there is no backpressure.
//     - out_last=1 on the n=N-1 pair.
//     - After that pair: in_ready=1 and LOAD in the same cycle that out_last is high.
//   Final encoder state equals the preload: this is the tail-biting property.
//   Throughput: one block per 2N cycles at minimum; load and encode never overlap.
//   Counter width $clog2(N); the wrap from N-1 to 0 is explicit, never natural overflow.
// TESTING
//   1. N=96, all-zero block -> 96 pairs, all X=0,Y=0; out_last only on pair 95.
//   2. All-ones block -> all 96 pairs X=1,Y=1 (five taps, odd parity).
//   3. u[0]=1, rest 0 -> X[0..6]=1111001, Y[0..6]=1011011; pairs 7..95 all 0.
//   4. u[95]=1, rest 0 (wrap check) -> X[0..5]=111001, Y[0..5]=011011;
//      X[95]=Y[95]=1; all others 0.
//   5. Randomizer output for input ACBCD2114DAE1577C6DBF4C9, with in_valid gapped
//      every 3rd cycle -> X/Y match a bit-exact C/Python model.
//      in_ready=0 for all 96 encode cycles; next block starts immediately after.
//   6. Reset asserted at load bit 40, and separately at encode pair 50
//      -> out_valid=0 the next cycle; a fresh full block then encodes correctly.

Source files
------------

// File: rtl/conv_encoder_tb.sv
// ----------------------------------------------------------------------------
// conv_encoder_tb : rate-1/2 tail-biting K=7 convolutional encoder (171/133 oct)
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module conv_encoder_tb #(
  parameter int N = 96
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic data_in,
  output logic in_ready,
  output logic out_valid,
  output logic x_out,
  output logic y_out,
  output logic out_last
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    ENCODE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  blk_q, blk_d;
  logic [6:1]    s_q, s_d;
  logic          valid_q, valid_d;
  logic          x_q, x_d;
  logic          y_q, y_d;
  logic          last_q, last_d;
  logic          u_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    s_d      = s_q;
    valid_d  = 1'b0;
    x_d      = 1'b0;
    y_d      = 1'b0;
    last_d   = 1'b0;
    in_ready = (state_q == LOAD);
    u_bit    = blk_q[cnt_q];

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          blk_d[cnt_q] = data_in;
          if (cnt_q == LAST) begin
            state_d = ENCODE;
            cnt_d   = '0;
            // Tail-biting preload: s[k] = u[N-k]; u[N-1] is arriving right now.
            s_d     = {blk_q[N-6], blk_q[N-5], blk_q[N-4],
                       blk_q[N-3], blk_q[N-2], data_in};
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ENCODE: begin
        valid_d = 1'b1;
        x_d     = u_bit ^ s_q[1] ^ s_q[2] ^ s_q[3] ^ s_q[6];
        y_d     = u_bit ^ s_q[2] ^ s_q[3] ^ s_q[5] ^ s_q[6];
        s_d     = {s_q[5:1], u_bit};
        if (cnt_q == LAST) begin
          last_d  = 1'b1;
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      last_q  <= last_d;
    end
  end

  // Block buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  assign out_valid = valid_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign out_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_tb.sv
// ----------------------------------------------------------------------------
// tb_conv_encoder_tb : directed vector bench for the tail-biting encoder
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_conv_encoder_tb;

  localparam int N       = 96;
  localparam int TIMEOUT = 400;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic in_valid = 1'b0;
  logic data_in  = 1'b0;
  logic in_ready, out_valid, x_out, y_out, out_last;

  int n_checks = 0;
  int n_fail   = 0;

  conv_encoder_tb #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .data_in  (data_in),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .x_out    (x_out),
    .y_out    (y_out),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] u;
    logic [N-1:0] x;
    logic [N-1:0] y;
    bit           gap;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // Reference: encoder state s[k] is u[n-k] taken circularly over the block.
  function automatic void ref_enc(input logic [N-1:0] u,
                                  output logic [N-1:0] x, output logic [N-1:0] y);
    for (int n = 0; n < N; n++) begin
      x[n] = u[n] ^ u[(n+N-1)%N] ^ u[(n+N-2)%N] ^ u[(n+N-3)%N] ^ u[(n+N-6)%N];
      y[n] = u[n] ^ u[(n+N-2)%N] ^ u[(n+N-3)%N] ^ u[(n+N-5)%N] ^ u[(n+N-6)%N];
    end
  endfunction

  // Called at a negedge; returns at the negedge after the last accepted bit.
  task automatic send_bits(input logic [N-1:0] u, input int nbits, input bit gap);
    int k   = 0;
    int cyc = 0;
    while (k < nbits) begin
      check($sformatf("in_ready_load[%0d]", k), in_ready, 1);
      in_valid = !(gap && (cyc % 3 == 2));
      data_in  = in_valid ? u[k] : 1'($urandom_range(0, 1));
      @(posedge clk);
      if (in_valid) k++;
      cyc++;
      if (cyc > TIMEOUT) begin
        check("load_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge showing pair npairs-1.
  task automatic collect(input logic [N-1:0] ex, input logic [N-1:0] ey,
                         input int npairs, input bit garbage);
    int idx    = 0;
    int waited = 0;
    while (1) begin
      if (out_valid) begin
        check($sformatf("xy[%0d]", idx), {x_out, y_out}, {ex[idx], ey[idx]});
        check($sformatf("out_last[%0d]", idx), out_last, (idx == N-1));
        check($sformatf("in_ready_enc[%0d]", idx), in_ready, (idx == N-1));
        idx++;
      end else if (idx > 0) begin
        check($sformatf("out_valid_gap[%0d]", idx), out_valid, 1);
        break;
      end
      if (idx >= npairs) break;
      if (waited >= TIMEOUT) begin
        check("out_timeout", 1, 0);
        break;
      end
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    data_in  = 1'b0;
  endtask

  initial begin
    logic [N-1:0] tx, ty;

    tbl[0] = '{u: '0, x: '0, y: '0, gap: 1'b0};
    tbl[1] = '{u: '1, x: '1, y: '1, gap: 1'b0};
    tbl[2] = '{u: 96'h1, x: 96'h4F, y: 96'h6D, gap: 1'b0};
    tbl[3] = '{u: {1'b1, 95'b0}, x: {1'b1, 89'b0, 6'h27},
               y: {1'b1, 89'b0, 6'h36}, gap: 1'b0};
    // Randomizer output for input ACBCD2114DAE1577C6DBF4C9, sent MSB first.
    tbl[4].u   = rev(96'h558AC4A53A1724E163AC2BF9);
    tbl[4].gap = 1'b1;
    ref_enc(tbl[4].u, tx, ty);
    tbl[4].x = tx;
    tbl[4].y = ty;
    tbl[5].u   = 96'hDEADBEEF_0123456789ABCDEF;
    tbl[5].gap = 1'b1;
    ref_enc(tbl[5].u, tx, ty);
    tbl[5].x = tx;
    tbl[5].y = ty;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_out",     x_out,     0);
    check("rst_y_out",     y_out,     0);
    check("rst_out_last",  out_last,  0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_bits(tbl[i].u, N, tbl[i].gap);
      collect(tbl[i].x, tbl[i].y, N, tbl[i].gap);
    end

    // Reset while loading bit 40, then a fresh block.
    send_bits(tbl[5].u, 40, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    data_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstload_out_valid", out_valid, 0);
    check("rstload_in_ready",  in_ready,  1);
    reset    = 1'b0;
    in_valid = 1'b0;
    send_bits(tbl[2].u, N, 1'b0);
    collect(tbl[2].x, tbl[2].y, N, 1'b0);

    // Reset at encode pair 50, then a fresh block.
    send_bits(tbl[4].u, N, 1'b0);
    collect(tbl[4].x, tbl[4].y, 50, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstenc_out_valid", out_valid, 0);
    check("rstenc_in_ready",  in_ready,  1);
    check("rstenc_out_last",  out_last,  0);
    reset = 1'b0;
    send_bits(tbl[3].u, N, 1'b0);
    collect(tbl[3].x, tbl[3].y, N, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
